vec_mac_datapath: RTL and testbench
===================================

Name: vec_mac_datapath

Overview:
- Four-lane multiply-accumulate datapath for the vector processor. It consumes the per-lane enable strobes and save_c from the sequencing controller.
- Per lane k, operands A[k] and B[k] are loaded from a shared operand bus and C[k] from a coefficient bus. First stage: S1[k] = A[k]*B[k] + C[k]. Second stage: ACC[k] += S1[k], saturating.
- Stage F emits a saturated DW-bit result per lane, with a valid pulse.
- Purely enable-driven: no internal schedule. Ordering is owned by the controller.

Parameters:
- DW, 8, operand/result width (unsigned).
- AW, 24, accumulator width; must be >= 2*DW+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- din  in  DW  operand bus, sampled by en_a*/en_b*
- cin  in  DW  coefficient bus, sampled by save_c
- en_a1..en_a4  in  1 each  load A[k] <= din
- en_b1..en_b4  in  1 each  load B[k] <= din
- save_c  in  1  C[c_idx] <= cin; c_idx++
- en_add1_1..en_add1_4  in  1 each  S1[k] <= A[k]*B[k] + C[k]
- en_add2_1..en_add2_4  in  1 each  ACC[k] <= sat(ACC[k] + S1[k])
- en_f1..en_f4  in  1 each  emit lane k result
- acc_clr  in  1  synchronous clear of all ACC[k] and ovf
- f_out  out  DW  saturated result
- f_valid  out  1  one-cycle pulse, f_out/f_idx valid
- f_idx  out  2  lane of f_out (0..3 = lanes 1..4)
- ovf  out  1  sticky: some ACC saturated since last clear/reset

Behaviour:
- Reset (async, immediate):
  - A, B, C, S1 and ACC cleared to 0; c_idx = 0.
  - f_out = 0, f_valid = 0, f_idx = 0, ovf = 0.
  - Reset mid-operation discards all partial state; there is no recovery.
- All register updates happen on the rising clk edge when the enable is high. Every stage reads the pre-edge values of its sources.
  - Same-cycle en_a[k] + en_add1_k: add1 uses the old A[k].
  - Same-cycle en_add1_k + en_add2_k: add2 uses the old S1[k].
  - Same-cycle en_add2_k + en_f[k]: F uses the old ACC[k].
- A lane may have en_a[k] and en_b[k] high in the same cycle; both load din.
- save_c:
  - C[c_idx] <= cin; c_idx <= c_idx+1 mod 4 (3 wraps to 0).
  - Independent of en_a*, so a simultaneous A-load and C-capture is legal.
- add1 arithmetic: product is 2*DW bits; sum is 2*DW+1 bits, zero-extended to AW. It cannot overflow.
- add2 arithmetic:
  - sum = ACC[k] + S1[k] in AW+1 bits.
  - If the sum exceeds 2^AW-1, ACC[k] <= 2^AW-1 and ovf <= 1.
- acc_clr:
  - ACC[k] <= 0 for all k; ovf <= 0.
  - Has priority over a same-cycle en_add2_k: the result is 0 and ovf stays 0.
  - Does not affect A, B, C, S1 or c_idx.
- F stage, 1-cycle latency:
  - Edge with en_f[k] high: f_out <= (ACC[k] > 2^DW-1) ? 2^DW-1 : ACC[k][DW-1:0]; f_idx <= k; f_valid <= 1.
  - Otherwise f_valid <= 0; f_out and f_idx hold.
  - Multiple en_f high in one cycle: lowest lane wins. The others are dropped, with no error flag. Well-formed schedules never do this.

Decomposition:
- Shared package vec_pkg: NLANES = 4, lane index type (2 bits), helper constants for saturation bounds (DW max, AW max).
- One natural sub-module, vec_mac_lane: holds A, B, C-slot write port, S1 and ACC with saturation and ovf output.
  - Instantiate it 4 times.
  - The top holds c_idx, the F output mux/priority and the ovf OR-reduce (sticky).

Test Plan:
1. Basic MAC, DW=8, AW=24:
   - Stimulus: load A=[3,5,7,9], B=[2,4,6,8], four save_c with cin=1, then en_add1_1..4, en_add2_1..4, en_f1..4 on successive cycles.
   - Required: f_out = 7, 21, 43, 73 with f_idx 0..3, each f_valid a single-cycle pulse one cycle after its en_f. ovf = 0.
2. Accumulate:
   - Stimulus: continue test 1 with a second en_add2_1..4 (no new add1), then en_f1..4.
   - Required: 14, 42, 86, 146.
   - Then acc_clr, then en_f1 -> 0.
3. Output saturation:
   - Stimulus: A1 = B1 = 255, C1 = 255 (c_idx at 0), add1, add2, en_f1.
   - Required: ACC1 = 65280, f_out = 255, ovf = 0.
4. Accumulator saturation, AW=17:
   - Stimulus: repeat the add2 of test 3 three times.
   - Required: ACC1 = 130560 after the second add2, then 131071 with ovf = 1 after the third.
   - ovf stays 1 until acc_clr; acc_clr in the same cycle as en_add2_1 leaves ACC1 = 0.
5. Same-cycle ordering:
   - Stimulus: en_a1 with din = 10 together with en_add1_1, where old A1 = 3, B1 = 2, C1 = 1.
   - Required: S1 = 7, not 21.
   - Also: save_c five times -> c_idx wraps and the fifth cin lands in C1.
6. Reset mid-operation:
   - Stimulus: assert rst asynchronously between add1 and add2.
   - Required: all outputs 0 immediately; after release, en_add2_1 + en_f1 yields f_out = 0, and save_c writes C1.

Source files
------------

// File: rtl/vec_pkg.sv
// vec_pkg: shared lane count, lane index type and saturation bound helper for the vector MAC.
package vec_pkg;
    localparam int NLANES = 4;
    localparam int DW_DEF = 8;
    localparam int AW_DEF = 24;
    typedef logic [1:0] lane_idx_t;
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction
endpackage

// File: rtl/vec_mac_lane.sv
// vec_mac_lane: one MAC lane holding A, B, C, S1 and a saturating accumulator.
module vec_mac_lane
    import vec_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] cin,
    input  logic          en_a,
    input  logic          en_b,
    input  logic          c_we,
    input  logic          en_add1,
    input  logic          en_add2,
    input  logic          acc_clr,
    output logic [AW-1:0] acc,
    output logic          sat_hit
);
    localparam logic [AW-1:0] ACC_MAX = AW'(sat_max(AW));
    logic [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [AW-1:0] s1_q, s1_d, acc_q, acc_d;
    logic [2*DW:0] mac;
    logic [AW:0]   sum;
    always_comb begin
        a_d     = en_a ? din : a_q;
        b_d     = en_b ? din : b_q;
        c_d     = c_we ? cin : c_q;
        mac     = (2*DW+1)'(a_q) * (2*DW+1)'(b_q) + (2*DW+1)'(c_q);
        s1_d    = en_add1 ? AW'(mac) : s1_q;
        sum     = {1'b0, acc_q} + {1'b0, s1_q};
        sat_hit = en_add2 && !acc_clr && sum[AW];
        acc_d   = acc_clr ? '0 : !en_add2 ? acc_q : sum[AW] ? ACC_MAX : sum[AW-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            s1_q  <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            s1_q  <= s1_d;
            acc_q <= acc_d;
        end
    end
    assign acc = acc_q;
endmodule

// File: rtl/vec_mac_datapath.sv
// vec_mac_datapath: four enable-driven MAC lanes with coefficient slot pointer,
// lowest-lane-wins saturated output stage and sticky overflow flag.
module vec_mac_datapath
    import vec_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] cin,
    input  logic          en_a1,
    input  logic          en_a2,
    input  logic          en_a3,
    input  logic          en_a4,
    input  logic          en_b1,
    input  logic          en_b2,
    input  logic          en_b3,
    input  logic          en_b4,
    input  logic          save_c,
    input  logic          en_add1_1,
    input  logic          en_add1_2,
    input  logic          en_add1_3,
    input  logic          en_add1_4,
    input  logic          en_add2_1,
    input  logic          en_add2_2,
    input  logic          en_add2_3,
    input  logic          en_add2_4,
    input  logic          en_f1,
    input  logic          en_f2,
    input  logic          en_f3,
    input  logic          en_f4,
    input  logic          acc_clr,
    output logic [DW-1:0] f_out,
    output logic          f_valid,
    output logic [1:0]    f_idx,
    output logic          ovf
);
    localparam logic [AW-1:0] DW_MAX = AW'(sat_max(DW));
    logic [NLANES-1:0] en_a, en_b, en_add1, en_add2, en_f, sat_hit;
    logic [AW-1:0]     acc [NLANES];
    lane_idx_t         c_idx_q, c_idx_d, f_idx_q, f_idx_d;
    logic [DW-1:0]     f_out_q, f_out_d;
    logic              f_valid_q, f_valid_d, ovf_q, ovf_d;

    assign en_a    = {en_a4, en_a3, en_a2, en_a1};
    assign en_b    = {en_b4, en_b3, en_b2, en_b1};
    assign en_add1 = {en_add1_4, en_add1_3, en_add1_2, en_add1_1};
    assign en_add2 = {en_add2_4, en_add2_3, en_add2_2, en_add2_1};
    assign en_f    = {en_f4, en_f3, en_f2, en_f1};

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        vec_mac_lane #(.DW(DW), .AW(AW)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .din     (din),
            .cin     (cin),
            .en_a    (en_a[k]),
            .en_b    (en_b[k]),
            .c_we    (save_c && c_idx_q == lane_idx_t'(k)),
            .en_add1 (en_add1[k]),
            .en_add2 (en_add2[k]),
            .acc_clr (acc_clr),
            .acc     (acc[k]),
            .sat_hit (sat_hit[k])
        );
    end

    // Descending scan so the lowest enabled lane is the one that sticks.
    always_comb begin
        f_out_d   = f_out_q;
        f_idx_d   = f_idx_q;
        f_valid_d = 1'b0;
        for (int k = NLANES - 1; k >= 0; k--) begin
            if (en_f[k]) begin
                f_out_d   = acc[k] > DW_MAX ? '1 : acc[k][DW-1:0];
                f_idx_d   = lane_idx_t'(k);
                f_valid_d = 1'b1;
            end
        end
        c_idx_d = save_c ? c_idx_q + 2'd1 : c_idx_q;
        ovf_d   = acc_clr ? 1'b0 : ovf_q | (|sat_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_idx_q   <= '0;
            f_out_q   <= '0;
            f_idx_q   <= '0;
            f_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            c_idx_q   <= c_idx_d;
            f_out_q   <= f_out_d;
            f_idx_q   <= f_idx_d;
            f_valid_q <= f_valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign f_out   = f_out_q;
    assign f_idx   = f_idx_q;
    assign f_valid = f_valid_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_vec_mac_datapath.sv
// tb_vec_mac_datapath: drives AW=24 and AW=17 instances with identical stimulus and
// compares both against an arithmetic reference model plus hand-derived expectations.
module tb_vec_mac_datapath;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] din = '0, cin = '0;
    logic [3:0] ea = '0, eb = '0, e1 = '0, e2 = '0, ef = '0;
    logic sc = 1'b0, clr = 1'b0;
    logic [7:0] fo [2];
    logic fv [2], ov [2];
    logic [1:0] fi [2];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    vec_mac_datapath #(.DW(8), .AW(24)) u_d24 (
        .clk(clk), .rst(rst), .din(din), .cin(cin),
        .en_a1(ea[0]), .en_a2(ea[1]), .en_a3(ea[2]), .en_a4(ea[3]),
        .en_b1(eb[0]), .en_b2(eb[1]), .en_b3(eb[2]), .en_b4(eb[3]),
        .save_c(sc),
        .en_add1_1(e1[0]), .en_add1_2(e1[1]), .en_add1_3(e1[2]), .en_add1_4(e1[3]),
        .en_add2_1(e2[0]), .en_add2_2(e2[1]), .en_add2_3(e2[2]), .en_add2_4(e2[3]),
        .en_f1(ef[0]), .en_f2(ef[1]), .en_f3(ef[2]), .en_f4(ef[3]),
        .acc_clr(clr), .f_out(fo[0]), .f_valid(fv[0]), .f_idx(fi[0]), .ovf(ov[0])
    );

    vec_mac_datapath #(.DW(8), .AW(17)) u_d17 (
        .clk(clk), .rst(rst), .din(din), .cin(cin),
        .en_a1(ea[0]), .en_a2(ea[1]), .en_a3(ea[2]), .en_a4(ea[3]),
        .en_b1(eb[0]), .en_b2(eb[1]), .en_b3(eb[2]), .en_b4(eb[3]),
        .save_c(sc),
        .en_add1_1(e1[0]), .en_add1_2(e1[1]), .en_add1_3(e1[2]), .en_add1_4(e1[3]),
        .en_add2_1(e2[0]), .en_add2_2(e2[1]), .en_add2_3(e2[2]), .en_add2_4(e2[3]),
        .en_f1(ef[0]), .en_f2(ef[1]), .en_f3(ef[2]), .en_f4(ef[3]),
        .acc_clr(clr), .f_out(fo[1]), .f_valid(fv[1]), .f_idx(fi[1]), .ovf(ov[1])
    );

    // Reference model: plain integer state per lane, one accumulator set per instance.
    longint ma [4], mb [4], mc [4], ms1 [4], macc [2][4], amax [2], mfo [2];
    int mci, mfi [2];
    bit mfv [2], mov [2];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            ma[k] = 0; mb[k] = 0; mc[k] = 0; ms1[k] = 0;
            macc[0][k] = 0; macc[1][k] = 0;
        end
        mci = 0;
        for (int d = 0; d < 2; d++) begin
            mfo[d] = 0; mfi[d] = 0; mfv[d] = 0; mov[d] = 0;
        end
    endtask

    // Updates are ordered so each stage reads values not yet advanced this cycle.
    task automatic model_step();
        int sel = -1;
        for (int k = 3; k >= 0; k--) if (ef[k]) sel = k;
        for (int d = 0; d < 2; d++) begin
            mfv[d] = sel >= 0;
            if (sel >= 0) begin
                mfo[d] = macc[d][sel] > 255 ? 255 : macc[d][sel];
                mfi[d] = sel;
            end
            for (int k = 0; k < 4; k++) begin
                if (clr) macc[d][k] = 0;
                else if (e2[k]) begin
                    if (macc[d][k] + ms1[k] > amax[d]) begin
                        macc[d][k] = amax[d];
                        mov[d] = 1;
                    end else macc[d][k] = macc[d][k] + ms1[k];
                end
            end
            if (clr) mov[d] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            if (e1[k]) ms1[k] = ma[k] * mb[k] + mc[k];
            if (ea[k]) ma[k] = din;
            if (eb[k]) mb[k] = din;
        end
        if (sc) begin
            mc[mci] = cin;
            mci = (mci + 1) % 4;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d f_out", tag, d), 32'(fo[d]), 32'(mfo[d]));
            chk($sformatf("%s d%0d f_valid", tag, d), 32'(fv[d]), 32'(mfv[d]));
            chk($sformatf("%s d%0d f_idx", tag, d), 32'(fi[d]), 32'(mfi[d]));
            chk($sformatf("%s d%0d ovf", tag, d), 32'(ov[d]), 32'(mov[d]));
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d f_out", tag, d), 32'(fo[d]), 0);
            chk($sformatf("%s d%0d f_valid", tag, d), 32'(fv[d]), 0);
            chk($sformatf("%s d%0d f_idx", tag, d), 32'(fi[d]), 0);
            chk($sformatf("%s d%0d ovf", tag, d), 32'(ov[d]), 0);
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk_model(tag);
        ea = '0; eb = '0; e1 = '0; e2 = '0; ef = '0; sc = 1'b0; clr = 1'b0;
    endtask

    task automatic go(input string tag, input logic [3:0] a, b, s1, s2, f,
                      input logic s, c, input logic [7:0] d, ci);
        ea = a; eb = b; e1 = s1; e2 = s2; ef = f; sc = s; clr = c; din = d; cin = ci;
        cycle(tag);
    endtask

    typedef struct {
        logic [3:0] a, b, s1, s2, f;
        logic       s, c;
        logic [7:0] d, ci;
        logic [7:0] xf;
        logic       xv;
        logic [1:0] xi;
    } row_t;
    row_t tbl [$];

    function automatic row_t mk(input logic [3:0] a, b, s1, s2, f, input logic s, c,
                                input logic [7:0] d, ci, xf, input logic xv,
                                input logic [1:0] xi);
        row_t r;
        r.a = a; r.b = b; r.s1 = s1; r.s2 = s2; r.f = f; r.s = s; r.c = c;
        r.d = d; r.ci = ci; r.xf = xf; r.xv = xv; r.xi = xi;
        return r;
    endfunction

    initial begin
        amax[0] = (longint'(1) << 24) - 1;
        amax[1] = (longint'(1) << 17) - 1;
        model_reset();
        #2;
        chk_zero("reset");
        #10 rst = 1'b0;

        // Tests 1 and 2: basic MAC, accumulate, clear.
        tbl.push_back(mk(4'h1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(4'h2, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0));
        tbl.push_back(mk(4'h4, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0));
        tbl.push_back(mk(4'h8, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h8, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 0, 0, 0, 7, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'h2, 0, 0, 0, 0, 21, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 4'h4, 0, 0, 0, 0, 43, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 4'h8, 0, 0, 0, 0, 73, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 73, 0, 3));
        tbl.push_back(mk(0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 73, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 0, 0, 0, 14, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'h2, 0, 0, 0, 0, 42, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 4'h4, 0, 0, 0, 0, 86, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 4'h8, 0, 0, 0, 0, 146, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 146, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 0, 0, 0, 0, 1, 0));
        foreach (tbl[i]) begin
            go($sformatf("row%0d", i), tbl[i].a, tbl[i].b, tbl[i].s1, tbl[i].s2, tbl[i].f,
               tbl[i].s, tbl[i].c, tbl[i].d, tbl[i].ci);
            chk($sformatf("row%0d f_out", i), 32'(fo[0]), 32'(tbl[i].xf));
            chk($sformatf("row%0d f_valid", i), 32'(fv[0]), 32'(tbl[i].xv));
            chk($sformatf("row%0d f_idx", i), 32'(fi[0]), 32'(tbl[i].xi));
            chk($sformatf("row%0d ovf", i), 32'(ov[0]), 0);
        end

        // Test 3: output saturation (ACC1 = 65280 clamps to 255).
        go("t3 load", 4'h1, 4'h1, 0, 0, 0, 1, 0, 255, 255);
        go("t3 add1", 0, 0, 4'h1, 0, 0, 0, 0, 0, 0);
        go("t3 add2", 0, 0, 0, 4'h1, 0, 0, 0, 0, 0);
        go("t3 f", 0, 0, 0, 0, 4'h1, 0, 0, 0, 0);
        chk("t3 f_out", 32'(fo[0]), 255);
        chk("t3 ovf", 32'(ov[0]), 0);

        // Test 4: AW=17 saturates on the third add2; ovf is sticky until acc_clr.
        go("t4 add2b", 0, 0, 0, 4'h1, 0, 0, 0, 0, 0);
        chk("t4 ovf17 at 130560", 32'(ov[1]), 0);
        go("t4 add2c", 0, 0, 0, 4'h1, 0, 0, 0, 0, 0);
        chk("t4 ovf17 sat", 32'(ov[1]), 1);
        chk("t4 ovf24 no sat", 32'(ov[0]), 0);
        go("t4 hold", 0, 0, 0, 0, 4'h1, 0, 0, 0, 0);
        chk("t4 ovf17 sticky", 32'(ov[1]), 1);
        chk("t4 f17", 32'(fo[1]), 255);
        go("t4 clr+add2", 0, 0, 0, 4'h1, 0, 0, 1, 0, 0);
        chk("t4 ovf17 cleared", 32'(ov[1]), 0);
        go("t4 f after clr", 0, 0, 0, 0, 4'h1, 0, 0, 0, 0);
        chk("t4 acc17 zero", 32'(fo[1]), 0);
        chk("t4 acc24 zero", 32'(fo[0]), 0);

        // Test 5: realign c_idx to 0, then five saves wrap so the fifth lands in C1.
        for (int i = 0; i < 3; i++) go("t5 align", 0, 0, 0, 0, 0, 1, 0, 0, 9);
        go("t5 A1", 4'h1, 0, 0, 0, 0, 1, 0, 3, 50);
        go("t5 B1", 0, 4'h1, 0, 0, 0, 1, 0, 2, 60);
        go("t5 c3", 0, 0, 0, 0, 0, 1, 0, 0, 70);
        go("t5 c4", 0, 0, 0, 0, 0, 1, 0, 0, 80);
        go("t5 c1 wrap", 0, 0, 0, 0, 0, 1, 0, 0, 1);
        go("t5 a1+add1", 4'h1, 0, 4'h9, 0, 0, 0, 0, 10, 0);
        go("t5 add2", 0, 0, 0, 4'h9, 0, 0, 0, 0, 0);
        go("t5 f1", 0, 0, 0, 0, 4'h1, 0, 0, 0, 0);
        chk("t5 old A used", 32'(fo[0]), 7);
        go("t5 f4", 0, 0, 0, 0, 4'h8, 0, 0, 0, 0);
        chk("t5 C4 slot", 32'(fo[0]), 152);
        go("t5 add1 new A", 0, 0, 4'h1, 0, 0, 0, 0, 0, 0);
        go("t5 add2 new", 0, 0, 0, 4'h1, 0, 0, 0, 0, 0);
        go("t5 f1 new", 0, 0, 0, 0, 4'h1, 0, 0, 0, 0);
        chk("t5 new A", 32'(fo[0]), 28);
        go("t5 multi f", 0, 0, 0, 0, 4'hA, 0, 0, 0, 0);
        chk("t5 lowest lane wins", 32'(fi[0]), 1);

        // Test 6: asynchronous reset between add1 and add2.
        go("t6 add1", 0, 0, 4'h1, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk_zero("t6 async");
        model_reset();
        #3 rst = 1'b0;
        go("t6 add2+f", 0, 0, 0, 4'h1, 4'h1, 0, 0, 0, 0);
        chk("t6 f_out", 32'(fo[0]), 0);
        chk("t6 f_valid", 32'(fv[0]), 1);
        go("t6 C1", 4'h1, 4'h1, 0, 0, 0, 1, 0, 1, 77);
        go("t6 add1", 0, 0, 4'h1, 0, 0, 0, 0, 0, 0);
        go("t6 add2", 0, 0, 0, 4'h1, 0, 0, 0, 0, 0);
        go("t6 f", 0, 0, 0, 0, 4'h1, 0, 0, 0, 0);
        chk("t6 C1 after reset", 32'(fo[0]), 78);

        // Randomized traffic, model-checked every cycle on both widths.
        for (int i = 0; i < 400; i++) begin
            go($sformatf("rnd%0d", i), 4'($urandom), 4'($urandom), 4'($urandom),
               4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
               1'($urandom), $urandom_range(0, 24) == 0,
               ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
